// File: rtl/bicubic_wgt_sched.sv
// bicubic_wgt_sched: walks destination rows, issues Q.8 phases to the weight pipeline, queues returned weights with clamped row tags.
module bicubic_wgt_sched #(
  parameter int WGT_LAT    = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int IDX_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] dst_rows,
  input  logic [IDX_W-1:0] src_rows,
  input  logic [15:0]      step,
  output logic             busy,
  output logic             done,
  output logic             wgt_issue,
  output logic [8:0]       wgt_blend,
  input  logic [8:0]       wgt_y0,
  input  logic [8:0]       wgt_y1,
  input  logic [8:0]       wgt_y2,
  input  logic [8:0]       wgt_y3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_row,
  output logic [8:0]       out_w0,
  output logic [8:0]       out_w1,
  output logic [8:0]       out_w2,
  output logic [8:0]       out_w3
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [IDX_W-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [27:0] acc;
  logic [IDX_W-1:0] cnt, dst_q, src_q, src_m1, tag;
  logic [15:0] step_q;
  logic [19:0] ipart;
  logic [WGT_LAT-1:0] dl_v;
  logic [IDX_W-1:0] dl_tag [WGT_LAT];
  logic [IDX_W+35:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic zero_done, issue, push, pop, last;
  int inflight;
  always_comb begin
    inflight = $countones(dl_v);
    issue = state == RUN && (int'(occ) + inflight < FIFO_DEPTH);
    last = cnt == dst_q - ONE;
    src_m1 = src_q - ONE;
    ipart = acc[27:8];
    tag = src_q == '0 ? '0 : ipart > {{(20-IDX_W){1'b0}}, src_m1} ? src_m1 : ipart[IDX_W-1:0];
    push = dl_v[WGT_LAT-1];
    out_valid = occ != '0;
    pop = out_valid & out_ready;
    state_nx = state == IDLE  ? (start && dst_rows != '0 ? RUN : IDLE)
             : state == RUN   ? (issue && last ? DRAIN : RUN)
             : state == DRAIN ? (inflight == 0 && occ == '0 ? DONE : DRAIN)
             : IDLE;
    busy = state != IDLE;
    done = state == DONE || zero_done;
    wgt_issue = issue;
    wgt_blend = issue ? {1'b0, acc[7:0]} : '0;
    {out_row, out_w0, out_w1, out_w2, out_w3} = out_valid ? mem[rd_ptr] : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      dst_q <= '0;
      src_q <= '0;
      step_q <= '0;
      zero_done <= 1'b0;
      dl_v <= '0;
      dl_tag <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
    end else begin
      zero_done <= state == IDLE && start && dst_rows == '0;
      if (state == IDLE && start && dst_rows != '0) begin
        dst_q <= dst_rows;
        src_q <= src_rows;
        step_q <= step;
        acc <= '0;
        cnt <= '0;
      end else if (issue) begin
        acc <= acc + {12'b0, step_q};
        cnt <= cnt + ONE;
      end
      dl_v <= {dl_v[WGT_LAT-2:0], issue};
      dl_tag[0] <= tag;
      for (int i = 1; i < WGT_LAT; i++) dl_tag[i] <= dl_tag[i-1];
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end
  // FIFO storage needs no reset: occupancy gates every read
  always_ff @(posedge clk)
    if (rst_n && push) mem[wr_ptr] <= {dl_tag[WGT_LAT-1], wgt_y0, wgt_y1, wgt_y2, wgt_y3};
endmodule

// File: tb/tb_bicubic_wgt_sched.sv
// tb_bicubic_wgt_sched: scoreboard bench with a behavioural weight pipeline.
module tb_bicubic_wgt_sched;
  localparam int LAT = 5;
  localparam int DEPTH = 8;
  localparam int IW = 12;
  typedef struct packed {
    logic [IW-1:0] row;
    logic [8:0] w0, w1, w2, w3;
  } ent_t;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 0;
  logic [IW-1:0] dst_rows = '0, src_rows = '0;
  logic [15:0] step = '0;
  logic busy, done, wgt_issue, out_valid;
  logic [8:0] wgt_blend, wgt_y0, wgt_y1, wgt_y2, wgt_y3, out_w0, out_w1, out_w2, out_w3;
  logic [IW-1:0] out_row;
  logic [LAT-1:0] pv = '0;
  logic [8:0] pb [LAT];
  ent_t sb_q[$];
  logic [8:0] ph_q[$];
  ent_t got, held, e;
  logic [8:0] pe;
  int checks = 0, errors = 0, issues = 0, dones = 0, pending = 0;
  bit hold = 0;
  always #5 clk = ~clk;
  bicubic_wgt_sched #(.WGT_LAT(LAT), .FIFO_DEPTH(DEPTH), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dst_rows(dst_rows), .src_rows(src_rows),
    .step(step), .busy(busy), .done(done), .wgt_issue(wgt_issue), .wgt_blend(wgt_blend),
    .wgt_y0(wgt_y0), .wgt_y1(wgt_y1), .wgt_y2(wgt_y2), .wgt_y3(wgt_y3),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_w0(out_w0), .out_w1(out_w1), .out_w2(out_w2), .out_w3(out_w3));
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], wgt_issue === 1'b1};
    pb[0] <= wgt_blend;
    for (int i = 1; i < LAT; i++) pb[i] <= pb[i-1];
  end
  assign wgt_y0 = pv[LAT-1] ? 9'd256 - pb[LAT-1] : 9'h155;
  assign wgt_y1 = pv[LAT-1] ? pb[LAT-1] : 9'h0AA;
  assign wgt_y2 = pv[LAT-1] ? pb[LAT-1] + 9'd3 : 9'h133;
  assign wgt_y3 = pv[LAT-1] ? 9'h1FF - pb[LAT-1] : 9'h0CC;
  function automatic ent_t mk(logic [IW-1:0] row, logic [8:0] b);
    return '{row, 9'd256 - b, b, b + 9'd3, 9'h1FF - b};
  endfunction
  task automatic expect_frame(int dst, int src, int stp);
    for (int i = 0; i < dst; i++) begin
      longint a = longint'(i) * stp;
      int ip = int'(a >> 8);
      logic [IW-1:0] row = IW'(src == 0 ? 0 : (ip > src - 1 ? src - 1 : ip));
      logic [8:0] b = 9'(a & 255);
      ph_q.push_back(b);
      sb_q.push_back(mk(row, b));
    end
  endtask
  always @(negedge clk) begin
    got = {out_row, out_w0, out_w1, out_w2, out_w3};
    if (hold) begin
      checks++;
      if (out_valid !== 1'b1 || got !== held) begin
        errors++;
        $display("FAIL hold_stable got %h valid %b exp %h", got, out_valid, held);
      end
    end
    hold = out_valid === 1'b1 && out_ready === 1'b0;
    held = got;
    if (wgt_issue === 1'b1) begin
      issues++;
      pending++;
      checks++;
      if (ph_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue blend %0d", wgt_blend);
      end else begin
        pe = ph_q.pop_front();
        if (wgt_blend !== pe) begin
          errors++;
          $display("FAIL phase got %0d exp %0d", wgt_blend, pe);
        end
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      pending--;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop got %h", got);
      end else begin
        e = sb_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL pop_data got row %0d w %h exp row %0d w %h", got.row, got[35:0], e.row, e[35:0]);
        end
      end
    end
    if (wgt_issue === 1'b1 && pending > DEPTH) begin
      errors++;
      $display("FAIL credit outstanding %0d exp <= %0d", pending, DEPTH);
    end
    if (done === 1'b1) dones++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(int dst, int src, int stp);
    dst_rows = IW'(dst);
    src_rows = IW'(src);
    step = 16'(stp);
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1;
      else begin
        tick();
        if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, wgt_issue, wgt_blend, out_valid, out_row, out_w0, out_w1, out_w2, out_w3} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy %b done %b issue %b blend %h valid %b row %h", busy, done, wgt_issue, wgt_blend, out_valid, out_row);
    end
    tick();
    rst_n = 1;
    tick();
  endtask
  task automatic test_basic();
    bit ok;
    int d0 = dones;
    out_ready = 1;
    expect_frame(4, 8, 'h180);
    launch(4, 8, 'h180);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (wgt_issue !== (k <= 4)) begin
        errors++;
        $display("FAIL basic_issue cycle T+%0d got %b exp %b", k, wgt_issue, k <= 4);
      end
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
      end
      if (k >= 6) begin
        checks++;
        if (out_valid !== (k == 7)) begin
          errors++;
          $display("FAIL basic_first_valid cycle T+%0d got %b exp %b", k, out_valid, k == 7);
        end
      end
    end
    wait_done(100, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout done got 0 exp 1"); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got %b exp 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_done busy %b done %b exp 0 0", busy, done);
    end
    checks++;
    if (dones - d0 != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL basic_done_count got %0d left %0d exp 1 0", dones - d0, sb_q.size());
    end
    tick();
  endtask
  task automatic test_backpressure();
    bit ok;
    int i0 = issues;
    out_ready = 0;
    expect_frame(20, 32, 'h100);
    launch(20, 32, 'h100);
    repeat (30) @(negedge clk);
    checks++;
    if (issues - i0 != DEPTH) begin errors++; $display("FAIL bp_issue_cap got %0d exp %0d", issues - i0, DEPTH); end
    checks++;
    if (out_valid !== 1'b1 || out_row !== '0) begin
      errors++;
      $display("FAIL bp_head valid %b row %0d exp 1 0", out_valid, out_row);
    end
    tick();
    out_ready = 1;
    wait_done(300, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout done got 0 exp 1"); end
    checks++;
    if (issues - i0 != 20 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL bp_total issues %0d left %0d exp 20 0", issues - i0, sb_q.size());
    end
    tick();
  endtask
  task automatic test_clamp();
    bit ok;
    out_ready = 1;
    expect_frame(4, 3, 'h200);
    launch(4, 3, 'h200);
    wait_done(100, 0, ok);
    checks++;
    if (!ok || sb_q.size() != 0) begin
      errors++;
      $display("FAIL clamp_complete done %b left %0d exp 1 0", ok, sb_q.size());
    end
    tick();
  endtask
  task automatic test_zero_and_ignore();
    bit ok;
    int i0 = issues;
    out_ready = 1;
    launch(0, 5, 'h100);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wgt_issue !== 1'b0) begin
      errors++;
      $display("FAIL zero_done done %b busy %b issue %b exp 1 0 0", done, busy, wgt_issue);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || issues != i0) begin
      errors++;
      $display("FAIL zero_after done %b busy %b issues %0d exp 0 0 0", done, busy, issues - i0);
    end
    tick();
    expect_frame(6, 10, 'h0C0);
    launch(6, 10, 'h0C0);
    tick();
    dst_rows = 50;
    step = 16'h0300;
    start = 1;
    tick();
    start = 0;
    wait_done(100, 0, ok);
    checks++;
    if (!ok || issues - i0 != 6 || ph_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_start done %b issues %0d exp 1 6", ok, issues - i0);
    end
    tick();
  endtask
  task automatic test_reset_midframe();
    int i0 = issues;
    out_ready = 1;
    expect_frame(10, 16, 'h100);
    launch(10, 16, 'h100);
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({busy, done, wgt_issue, wgt_blend, out_valid, out_row, out_w0, out_w1, out_w2, out_w3} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs busy %b issue %b valid %b row %h", busy, wgt_issue, out_valid, out_row);
    end
    checks++;
    if (issues - i0 != 3) begin errors++; $display("FAIL midreset_issues got %0d exp 3", issues - i0); end
    sb_q.delete();
    ph_q.delete();
    pending = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || wgt_issue !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet cycle %0d valid %b issue %b exp 0 0", k, out_valid, wgt_issue);
      end
    end
    tick();
  endtask
  task automatic test_random();
    bit ok;
    for (int r = 0; r < 2; r++) begin
      int stp = r == 0 ? int'($urandom_range(1, 'hFFFF)) : int'($urandom_range(16, 'h300));
      int src = int'($urandom_range(1, 4095));
      int d0 = dones;
      out_ready = 1;
      expect_frame(100, src, stp);
      launch(100, src, stp);
      wait_done(3000, 1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_timeout frame %0d done got 0 exp 1", r); end
      repeat (5) @(negedge clk);
      checks++;
      if (dones - d0 != 1 || sb_q.size() != 0 || ph_q.size() != 0) begin
        errors++;
        $display("FAIL rand_complete frame %0d dones %0d left %0d exp 1 0", r, dones - d0, sb_q.size());
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clamp();
    test_zero_and_ignore();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bicubic_wgt_sched.md
# bicubic_wgt_sched

Row scheduler for the vertical bicubic weight datapath. On `start`, it walks every destination row of a frame and accumulates the source position in Q.8 fixed point. Each cycle it may issue one fractional phase to the shared 4-tap weight pipeline (y0..y3 units), then captures the returned weights with their clamped source-row index into an output FIFO. Credit-based flow control guarantees the FIFO never overflows while downstream stalls.

## Interface
- `WGT_LAT`, 5, fixed latency in cycles from `wgt_issue` to valid `wgt_y0..y3`.
- `FIFO_DEPTH`, 8, output FIFO entries (power of 2, ≥2).
- `IDX_W`, 12, row index / row count width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  frame start pulse; sampled only in IDLE.
- `dst_rows`  in  IDX_W  destination rows this frame; latched on accepted `start`.
- `src_rows`  in  IDX_W  source rows; latched on accepted `start`; row index clamp bound.
- `step`  in  16  source rows per destination row, Q8.8; latched on accepted `start`.
- `busy`  out  1  high in RUN/DRAIN/DONE.
- `done`  out  1  one-cycle pulse at frame completion.
- `wgt_issue`  out  1  phase issue strobe to weight pipeline.
- `wgt_blend`  out  9  `{1'b0, frac[7:0]}` phase; coeffOne is the constant 9'd256 outside this block.
- `wgt_y0`..`wgt_y3`  in  9 each  weights returned from pipeline.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accept.
- `out_row`  out  IDX_W  clamped source row index of head.
- `out_w0`..`out_w3`  out  9 each  weights of head.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN: `start`=1 and `dst_rows`≠0. Latches params; `acc`=0; `cnt`=0.
- IDLE with `start`=1 and `dst_rows`=0: `done` pulses next cycle; stays IDLE; no issue.
- `start` outside IDLE: ignored.
- RUN:
  - Issue when `occ + inflight < FIFO_DEPTH`. `occ` is FIFO occupancy; `inflight` is the count of set bits in the valid delay line. A pop in the same cycle is not credited.
  - On issue: `wgt_issue`=1, `wgt_blend`={1'b0,`acc[7:0]`}.
  - Row tag = min(`acc[27:8]`, `src_rows`−1), or 0 when `src_rows`=0. The tag enters a WGT_LAT-deep delay line alongside the valid bit.
  - Then `acc` += `step`, `cnt` += 1. `acc` is 28 bits unsigned and cannot wrap: 4095·0xFFFF < 2^28.
  - Issue with `cnt`=`dst_rows`−1 → DRAIN.
- Capture: when the delay-line output valid is 1, push {tag, wgt_y0..y3} into the FIFO. The credit rule guarantees no push when full.
- DRAIN → DONE when `inflight`=0 and `occ`=0. DONE asserts `done` for one cycle, then returns to IDLE.
- FIFO is show-ahead. Pop on `out_valid & out_ready`. Simultaneous push and pop leaves `occ` unchanged. Pop while empty has no effect.
- `out_*` data is held stable while `out_valid`=1 and `out_ready`=0.
- Reset (`rst_n`=0 at a clock edge, in any state): FSM → IDLE; acc, cnt, delay line, and FIFO are cleared. Any weights returning after reset are discarded because the delay line is cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `wgt_issue`=0, `wgt_blend`=0, `out_valid`=0, `out_row`=0, `out_w0..3`=0.
- `start` at cycle T → first `wgt_issue` at T+1.
- Issue at cycle t → push at t+WGT_LAT → `out_valid` at t+WGT_LAT+1 (registered FIFO head).
- With defaults and `out_ready` held high, `wgt_issue` is asserted every cycle for `dst_rows` consecutive cycles.
- If `out_ready` is held low, at most FIFO_DEPTH issues occur, then `wgt_issue` stays low until pops free credit.
- `done` asserts one cycle after the last pop, in the DONE state, provided no returns remain outstanding.
- `busy` rises the cycle after an accepted `start` and falls in the cycle after `done`.

## Test plan
- `dst_rows`=4, `src_rows`=8, `step`=0x0180, `out_ready`=1 → `wgt_blend` = 0,128,0,128 on 4 consecutive cycles. `out_row` = 0,1,3,4 starting at T+WGT_LAT+2. Single `done` pulse.
- `out_ready`=0, `dst_rows`=20, `step`=0x0100 → exactly 8 issues, `out_valid`=1 with head row 0 held stable. Then raise `out_ready` → remaining 12 rows delivered in order, no loss or duplication.
- Clamp: `src_rows`=3, `step`=0x0200, `dst_rows`=4 → `out_row` = 0,2,2,2.
- `dst_rows`=0 with `start` → `done` pulse next cycle, no `wgt_issue`, `busy` stays 0. A `start` pulsed during RUN is ignored, and the issue count still equals the original `dst_rows`.
- Reset asserted 2 cycles after the first issue → all outputs 0 next cycle, FIFO empty. Returned weights are not pushed, and no `out_valid` follows.
- Random `out_ready` (50%), `dst_rows`=100, random `step` → scoreboard matches the reference row and phase sequence. `occ` never exceeds FIFO_DEPTH. Exactly one `done`.
